tone_counter_bank: RTL
======================

TONE_COUNTER_BANK -- requirements
Module: tone_counter_bank

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4, meaning the number of independent divider channels (1..16).
REQ-002 SHALL provide parameter WIDTH, default 20, meaning the divider/counter width in bits.
REQ-003 SHALL define CW = max(1, $clog2(CHANNELS)) as the channel-index width.
REQ-004 SHALL have port clock, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-005 SHALL have port clr, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port wr_en, input, 1 bit: configuration write strobe, sampled at the rising edge.
REQ-007 SHALL have port wr_ch, input, CW bits: target channel of the write.
REQ-008 SHALL have port wr_div, input, WIDTH bits: new divide value for the target channel.
REQ-009 SHALL have port wr_on, input, 1 bit: new enable for the target channel.
REQ-010 SHALL have port sync, input, 1 bit: synchronous phase-realign strobe for all channels.
REQ-011 SHALL have port square_out, output, CHANNELS bits: per-channel registered square wave.
REQ-012 SHALL have port tick_out, output, CHANNELS bits: per-channel registered one-cycle terminal-count pulse.
REQ-013 SHALL have port busy, output, CHANNELS bits: high while a written divide value is pending and not yet applied.

Function
REQ-014 Per channel, the block SHALL hold: cnt[WIDTH], div_act[WIDTH], div_pend[WIDTH], pend flag, on flag, square, tick.
REQ-015 A channel SHALL be running only when on=1 and div_act != 0.
REQ-016 While running, each cycle: if cnt == div_act, the channel SHALL set cnt to 0, toggle square, and assert tick for that cycle; otherwise it SHALL increment cnt and set tick to 0.
REQ-017 The tick period SHALL be div_act+1 cycles, and the square period SHALL be 2*(div_act+1) cycles with 50% duty.
REQ-018 When not running, the channel SHALL force cnt=0, square=0 and tick=0.
REQ-019 A write (wr_en=1, wr_ch < CHANNELS) SHALL update on from wr_on immediately (effective next edge) and SHALL load wr_div into div_pend with pend=1.
REQ-020 A pending divide on a running channel SHALL transfer to div_act only on that channel's terminal-count cycle, in the same edge as the wrap, so that no truncated or stretched half-period occurs.
REQ-021 A pending divide on a channel that is not running SHALL transfer to div_act on the edge following the write.
REQ-022 busy[i] SHALL equal pend[i] (registered, cleared on the edge of transfer).
REQ-023 A write with wr_ch >= CHANNELS SHALL be ignored with no state change.
REQ-024 A second write to the same channel while pend=1 SHALL overwrite div_pend; only the last value is applied.
REQ-025 On sync=1, every channel SHALL set cnt=0, square=0 and tick=0, and SHALL apply any pending divide immediately (pend cleared).
REQ-026 sync SHALL take priority over terminal count in the same cycle.
REQ-027 A write coincident with sync SHALL take effect with sync priority, i.e. the written divide becomes div_act that edge.
REQ-028 Writing wr_on=0 SHALL stop the channel at the next edge with square=0, regardless of phase.
REQ-029 Counters SHALL never exceed div_act; cnt arithmetic SHALL be WIDTH bits with no wrap beyond 2^WIDTH-1.

Reset
REQ-030 While clr=1, asynchronously and independent of clock: cnt=0, div_act=0, div_pend=0, pend=0, on=0, square_out=0, tick_out=0, busy=0.
REQ-031 Assertion of clr mid-period SHALL discard all phase and configuration; after release the channels SHALL stay idle until written.

Verification
REQ-032 Scenario 1: write ch0 div=3, on=1 -> tick_out[0] every 4 cycles, square_out[0] toggles every 4 cycles (period 8).
REQ-033 Scenario 2: ch0 running div=3; write div=1 at cnt=1 -> busy[0]=1 until the cnt==3 wrap, then tick every 2 cycles with no glitch; busy[0]=0 after the wrap.
REQ-034 Scenario 3: ch0 div=5, ch1 div=2, both running, pulse sync -> both square_out=0 and cnt=0 next cycle; first ticks 6 and 3 cycles later respectively.
REQ-035 Scenario 4: write wr_ch=CHANNELS (CHANNELS not a power of 2, e.g. 3) -> no output or busy change on any channel.
REQ-036 Scenario 5: ch2 running, assert clr for 1 cycle mid-period -> all outputs 0 immediately; no ticks after release until ch2 is re-written.
REQ-037 Scenario 6: write div=0, on=1 -> channel idle (square_out=0, tick_out=0), busy cleared next edge.

Source files
------------

// File: rtl/tone_cfg_if.sv
// Configuration write bus and phase-realign strobe for the tone counter bank.
interface tone_cfg_if #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 20
) ();
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic          wr_en;
   logic [CW-1:0] wr_ch;
   logic [WIDTH-1:0] wr_div;
   logic          wr_on;
   logic          sync;

   modport master (output wr_en, wr_ch, wr_div, wr_on, sync);
   modport slave  (input  wr_en, wr_ch, wr_div, wr_on, sync);
endinterface

// File: rtl/tone_counter_bank.sv
// Bank of independent programmable dividers producing a square wave and a
// terminal-count tick per channel; divide changes land on period boundaries.
module tone_counter_bank #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 20
) (
   input  logic                clock,
   input  logic                clr,
   tone_cfg_if.slave           cfg,
   output logic [CHANNELS-1:0] square_out,
   output logic [CHANNELS-1:0] tick_out,
   output logic [CHANNELS-1:0] busy
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] cnt;
      logic [WIDTH-1:0] div_act;
      logic [WIDTH-1:0] div_pend;
      logic             pend;
      logic             on;
      logic             square;
      logic             tick;

      logic hit;
      logic running;
      logic wrap;
      logic halt;

      // An out-of-range wr_ch can never equal a valid index, so it is ignored.
      always_comb begin
         hit     = cfg.wr_en && (cfg.wr_ch == CW'(i));
         running = on && (div_act != '0);
         wrap    = running && (cnt == div_act);
         halt    = hit && !cfg.wr_on;
      end

      // NOTE: every state register, divide values included, takes the async
      // reset so a clr mid-period leaves no stale phase or configuration.
      always_ff @(posedge clock or posedge clr) begin
         if (clr) begin
            cnt      <= '0;
            div_act  <= '0;
            div_pend <= '0;
            pend     <= 1'b0;
            on       <= 1'b0;
            square   <= 1'b0;
            tick     <= 1'b0;
         end else begin
            if (hit) on <= cfg.wr_on;

            if (cfg.sync) begin
               cnt    <= '0;
               square <= 1'b0;
               tick   <= 1'b0;
               pend   <= 1'b0;
               if (hit) begin
                  div_act  <= cfg.wr_div;
                  div_pend <= cfg.wr_div;
               end else if (pend) begin
                  div_act <= div_pend;
               end
            end else begin
               if (!running || halt) begin
                  cnt    <= '0;
                  square <= 1'b0;
                  tick   <= 1'b0;
               end else if (wrap) begin
                  cnt    <= '0;
                  square <= ~square;
                  tick   <= 1'b1;
               end else begin
                  cnt  <= cnt + 1'b1;
                  tick <= 1'b0;
               end

               // A fresh write supersedes any transfer so only the last value lands.
               if (hit) begin
                  div_pend <= cfg.wr_div;
                  pend     <= 1'b1;
               end else if (pend && (!running || wrap)) begin
                  div_act <= div_pend;
                  pend    <= 1'b0;
               end
            end
         end
      end

      assign square_out[i] = square;
      assign tick_out[i]   = tick;
      assign busy[i]       = pend;
   end
endmodule
